// File: rtl/core_commit_gen.sv
// core_commit_gen: registers WB retirements into a 1-cycle commit strobe,
// counts retired instructions and watches for commit starvation.
module core_commit_gen #(
  parameter int CNT_W     = 64,
  parameter int WDT_W     = 16,
  parameter int WDT_LIMIT = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_val,
  input  logic             wb_kill,
  input  logic [31:0]      wb_pc,
  input  logic             wdt_en,
  input  logic             wdt_clr,
  output logic             commit_val,
  output logic [31:0]      commit_pc,
  output logic [CNT_W-1:0] commit_cnt,
  output logic             wdt_hang
);

  if (WDT_LIMIT < 2 || 64'(WDT_LIMIT) >= (64'd1 << WDT_W)) begin : g_chk
    $error("WDT_LIMIT must satisfy 2 <= WDT_LIMIT < 2**WDT_W");
  end

  localparam logic [WDT_W-1:0] LAST = WDT_W'(WDT_LIMIT - 1);
  localparam logic [WDT_W-1:0] W1   = WDT_W'(1);
  localparam logic [CNT_W-1:0] C1   = CNT_W'(1);

  typedef enum logic [1:0] {
    OFF,
    RUN,
    HANG
  } wdt_e;

  wdt_e             state, state_n;
  logic [WDT_W-1:0] idle_cnt, idle_n;
  logic             hang_n;
  logic             commit;

  assign commit = wb_val & ~wb_kill;

  always_ff @(posedge clk) begin
    if (rst) begin
      commit_val <= 1'b0;
      commit_pc  <= '0;
      commit_cnt <= '0;
    end else begin
      commit_val <= commit;
      if (commit) begin
        commit_pc  <= wb_pc;
        commit_cnt <= commit_cnt + C1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= OFF;
      idle_cnt <= '0;
      wdt_hang <= 1'b0;
    end else begin
      state    <= state_n;
      idle_cnt <= idle_n;
      wdt_hang <= hang_n;
    end
  end

  // A clear always beats both a commit and the hang trigger.
  always_comb begin
    state_n = state;
    idle_n  = idle_cnt;
    hang_n  = wdt_hang;
    unique case (state)
      OFF: begin
        idle_n = '0;
        if (wdt_en) state_n = RUN;
      end
      RUN: begin
        if (!wdt_en) begin
          state_n = OFF;
          idle_n  = '0;
        end else if (wdt_clr || commit) begin
          idle_n = '0;
        end else if (idle_cnt == LAST) begin
          state_n = HANG;
          hang_n  = 1'b1;
        end else begin
          idle_n = idle_cnt + W1;
        end
      end
      HANG: begin
        if (wdt_clr) begin
          hang_n  = 1'b0;
          idle_n  = '0;
          state_n = wdt_en ? RUN : OFF;
        end
      end
      default: begin
        state_n = OFF;
        idle_n  = '0;
        hang_n  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_core_commit_gen.sv
// tb_core_commit_gen: directed stimulus, behavioural model checked every
// falling edge, plus literal expectations at key points.
module tb_core_commit_gen;

  localparam int CW  = 4;
  localparam int WW  = 16;
  localparam int LIM = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          wb_val;
  logic          wb_kill;
  logic [31:0]   wb_pc;
  logic          wdt_en;
  logic          wdt_clr;
  logic          commit_val;
  logic [31:0]   commit_pc;
  logic [CW-1:0] commit_cnt;
  logic          wdt_hang;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  core_commit_gen #(
    .CNT_W(CW),
    .WDT_W(WW),
    .WDT_LIMIT(LIM)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wb_val(wb_val),
    .wb_kill(wb_kill),
    .wb_pc(wb_pc),
    .wdt_en(wdt_en),
    .wdt_clr(wdt_clr),
    .commit_val(commit_val),
    .commit_pc(commit_pc),
    .commit_cnt(commit_cnt),
    .wdt_hang(wdt_hang)
  );

  // Model: retire events, a modular count, and a run of enabled idle cycles.
  bit          m_ok = 1'b0;
  bit          m_val;
  logic [31:0] m_pc;
  int          m_cnt;
  bit          m_hang;
  bit          m_arm;
  int          m_idle;

  always @(posedge clk) begin
    if (rst) begin
      m_ok   = 1'b1;
      m_val  = 1'b0;
      m_pc   = '0;
      m_cnt  = 0;
      m_hang = 1'b0;
      m_arm  = 1'b0;
      m_idle = 0;
    end else begin
      m_val = wb_val && !wb_kill;
      if (m_val) begin
        m_pc  = wb_pc;
        m_cnt = (m_cnt + 1) % (1 << CW);
      end
      if (m_hang) begin
        if (wdt_clr) begin
          m_hang = 1'b0;
          m_idle = 0;
          m_arm  = wdt_en;
        end
      end else if (!m_arm) begin
        m_idle = 0;
        m_arm  = wdt_en;
      end else if (!wdt_en) begin
        m_arm  = 1'b0;
        m_idle = 0;
      end else if (wdt_clr || m_val) begin
        m_idle = 0;
      end else begin
        m_idle = m_idle + 1;
        if (m_idle == LIM) m_hang = 1'b1;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic pin(input string nm, input logic [63:0] act,
                     input logic [63:0] mdl, input logic [63:0] exp);
    chk({nm, "_dut"}, act, exp);
    chk({nm, "_mdl"}, mdl, exp);
  endtask

  always @(negedge clk) begin
    if (m_ok) begin
      chk("val", 64'(commit_val), 64'(m_val));
      chk("pc", 64'(commit_pc), 64'(m_pc));
      chk("cnt", 64'(commit_cnt), 64'(m_cnt));
      chk("hang", 64'(wdt_hang), 64'(m_hang));
    end
  end

  task automatic step(input logic v, input logic k,
                      input logic [31:0] pc, input logic clr = 1'b0);
    wb_val  = v;
    wb_kill = k;
    wb_pc   = pc;
    wdt_clr = clr;
    @(negedge clk);
  endtask

  task automatic reset_cyc(input logic v = 1'b0,
                           input logic [31:0] pc = 32'h0);
    rst     = 1'b1;
    wb_val  = v;
    wb_kill = 1'b0;
    wb_pc   = pc;
    wdt_clr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    wb_val  = 1'b0;
    wb_kill = 1'b0;
    wb_pc   = '0;
    wdt_en  = 1'b0;
    wdt_clr = 1'b0;
    @(negedge clk);
    reset_cyc();
    pin("rst_val", 64'(commit_val), 64'(m_val), 64'd0);
    pin("rst_pc", 64'(commit_pc), 64'(m_pc), 64'd0);
    pin("rst_cnt", 64'(commit_cnt), 64'(m_cnt), 64'd0);
    pin("rst_hang", 64'(wdt_hang), 64'(m_hang), 64'd0);

    repeat (3) step(1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h100);
    pin("one_val", 64'(commit_val), 64'(m_val), 64'd1);
    pin("one_pc", 64'(commit_pc), 64'(m_pc), 64'h100);
    pin("one_cnt", 64'(commit_cnt), 64'(m_cnt), 64'd1);
    step(1'b0, 1'b1, 32'h999);
    pin("hold_val", 64'(commit_val), 64'(m_val), 64'd0);
    pin("hold_pc", 64'(commit_pc), 64'(m_pc), 64'h100);

    reset_cyc();
    step(1'b1, 1'b0, 32'h200);
    step(1'b1, 1'b1, 32'h204);
    pin("kill_val", 64'(commit_val), 64'(m_val), 64'd0);
    pin("kill_pc", 64'(commit_pc), 64'(m_pc), 64'h200);
    step(1'b1, 1'b0, 32'h208);
    step(1'b1, 1'b0, 32'h20C);
    pin("b2b_val", 64'(commit_val), 64'(m_val), 64'd1);
    pin("b2b_pc", 64'(commit_pc), 64'(m_pc), 64'h20C);
    pin("kill_cnt", 64'(commit_cnt), 64'(m_cnt), 64'd3);
    step(1'b0, 1'b0, 32'h0);

    reset_cyc();
    for (int i = 1; i <= 17; i++) begin
      step(1'b1, 1'b0, 32'h1000 + 32'(4 * i));
      if (i == 15) pin("wrap15", 64'(commit_cnt), 64'(m_cnt), 64'd15);
      if (i == 16) pin("wrap16", 64'(commit_cnt), 64'(m_cnt), 64'd0);
      if (i == 17) pin("wrap17", 64'(commit_cnt), 64'(m_cnt), 64'd1);
    end

    reset_cyc();
    wdt_en = 1'b1;
    step(1'b0, 1'b0, 32'h0);
    repeat (7) step(1'b0, 1'b0, 32'h0);
    pin("wdt7", 64'(wdt_hang), 64'(m_hang), 64'd0);
    step(1'b0, 1'b0, 32'h0);
    pin("wdt8", 64'(wdt_hang), 64'(m_hang), 64'd1);
    step(1'b1, 1'b0, 32'h300);
    pin("wdt_sticky", 64'(wdt_hang), 64'(m_hang), 64'd1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    pin("wdt_clr", 64'(wdt_hang), 64'(m_hang), 64'd0);
    repeat (7) step(1'b0, 1'b0, 32'h0);
    pin("wdt_re7", 64'(wdt_hang), 64'(m_hang), 64'd0);
    step(1'b0, 1'b0, 32'h0);
    pin("wdt_re8", 64'(wdt_hang), 64'(m_hang), 64'd1);

    step(1'b0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 100; i++) begin
      step(i % 8 == 7, 1'b0, 32'h400 + 32'(4 * i));
    end
    pin("near_miss", 64'(wdt_hang), 64'(m_hang), 64'd0);
    step(1'b1, 1'b0, 32'h600);
    repeat (7) step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    pin("clr_beats_trig", 64'(wdt_hang), 64'(m_hang), 64'd0);
    repeat (7) step(1'b0, 1'b0, 32'h0);
    pin("post_clr7", 64'(wdt_hang), 64'(m_hang), 64'd0);
    step(1'b0, 1'b0, 32'h0);
    pin("post_clr8", 64'(wdt_hang), 64'(m_hang), 64'd1);

    reset_cyc();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h700 + 32'(4 * i));
    pin("pre_rst_cnt", 64'(commit_cnt), 64'(m_cnt), 64'd5);
    reset_cyc(1'b1, 32'h800);
    pin("mid_val", 64'(commit_val), 64'(m_val), 64'd0);
    pin("mid_cnt", 64'(commit_cnt), 64'(m_cnt), 64'd0);
    pin("mid_hang", 64'(wdt_hang), 64'(m_hang), 64'd0);
    repeat (8) step(1'b0, 1'b0, 32'h0);
    pin("off_arm8", 64'(wdt_hang), 64'(m_hang), 64'd0);
    step(1'b0, 1'b0, 32'h0);
    pin("off_arm9", 64'(wdt_hang), 64'(m_hang), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/core_commit_gen.md
Name: core_commit_gen

Overview:
Retire-side producer of the core commit strobe. It sits at the end of the core pipeline after writeback, and turns writeback-stage events into a registered one-cycle commit pulse carrying the committed PC. It also maintains a retired-instruction counter and a no-commit watchdog. Its outputs drive the commit interface that the testbench commit monitor samples on the falling edge.

Parameters:
CNT_W, 64, width of the retired-instruction counter
WDT_W, 16, width of the watchdog idle counter
WDT_LIMIT, 1000, number of consecutive idle cycles that flags a hang; must satisfy 2 <= WDT_LIMIT < 2^WDT_W (elaboration-time check)

Ports:
clk  input  1  core clock; all state updates on posedge
rst  input  1  synchronous, active-high reset
wb_val  input  1  valid instruction in WB this cycle
wb_kill  input  1  WB instruction squashed (exception or flush); qualifies wb_val
wb_pc  input  32  PC of the WB instruction
wdt_en  input  1  watchdog enable
wdt_clr  input  1  clears the sticky hang flag and the idle counter
commit_val  output  1  one-cycle commit strobe (drives the commit interface val)
commit_pc  output  32  PC of the committed instruction; valid when commit_val=1
commit_cnt  output  CNT_W  total committed instructions
wdt_hang  output  1  sticky hang indication

Behaviour:
- Reset (rst=1 at posedge): commit_val=0, commit_pc=0, commit_cnt=0, wdt_hang=0, idle_cnt=0, FSM=OFF. rst overrides all other inputs in the same cycle.
- All outputs are flop outputs, so they are stable across the negedge sampling point.
- commit = wb_val & ~wb_kill. wb_kill with wb_val=0 has no effect.
- Latency is 1 cycle: commit at cycle N gives commit_val=1 and commit_pc=wb_pc in cycle N+1.
- When commit=0, commit_val is 0 and commit_pc holds its last value.
- Back-to-back commits produce commit_val high for consecutive cycles, one instruction per cycle.
- commit_cnt increments by 1 on the same edge that raises commit_val, so it always includes the instruction currently shown. It wraps from 2^CNT_W-1 to 0 silently.
- Watchdog FSM states: OFF, RUN, HANG.
  - OFF: idle_cnt is held at 0. Go to RUN when wdt_en=1.
  - RUN: if wdt_en=0, go to OFF and set idle_cnt=0. Else if commit, set idle_cnt=0. Else if idle_cnt==WDT_LIMIT-1, go to HANG and set wdt_hang=1. Else idle_cnt+1.
  - Net effect: wdt_hang rises on the edge that ends the WDT_LIMIT-th consecutive non-commit cycle while enabled.
  - HANG: wdt_hang stays 1 and idle_cnt is frozen. Commits do not clear it. wdt_clr=1 sets wdt_hang=0 and idle_cnt=0, then goes to RUN if wdt_en=1, otherwise OFF. wdt_en=0 alone does not leave HANG.
- wdt_clr in RUN or OFF: set idle_cnt=0 with no state change.
- wdt_clr together with commit: clear wins, idle_cnt=0. The commit is still emitted and counted.
- wdt_clr together with the hang-trigger condition: clear wins and no hang is raised.
- The watchdog never affects commit_val, commit_pc or commit_cnt.
- Reset mid-stream: the in-flight commit is dropped. commit_val is 0 in the cycle after the reset edge, and the counters restart from 0.

Test Plan:
- Reset then single commit: wb_val=1, wb_pc=0x100 at cycle 5. Next cycle commit_val=1, commit_pc=0x100, commit_cnt=1. Cycle after that, commit_val=0 and commit_pc stays 0x100.
- Kill filtering: 4 consecutive wb_val cycles with PCs 0x200/0x204/0x208/0x20C and wb_kill=1 on the 2nd. Exactly 3 pulses appear (0x200, 0x208, 0x20C; the last two back-to-back) and commit_cnt=3.
- Counter wrap: CNT_W=4, 17 commits. commit_cnt reads 15 after 15 commits, 0 after the 16th, and 1 after the 17th.
- Watchdog trigger: WDT_LIMIT=8, wdt_en=1, no commits. wdt_hang=0 after 7 idle cycles and 1 after the 8th. A later commit leaves wdt_hang=1. wdt_clr then gives wdt_hang=0, and hang reasserts 8 idle cycles later.
- Watchdog near-miss: WDT_LIMIT=8, commits every 8th cycle (7 idle cycles between) for 100 cycles -> wdt_hang is never 1. wdt_clr asserted on the would-be trigger cycle of an 8-idle gap -> no hang.
- Reset mid-operation: rst=1 on the cycle a commit occurs with commit_cnt=5. Next cycle commit_val=0, commit_cnt=0, wdt_hang=0, FSM=OFF.
